henon_card_drawer: RTL and testbench

//   Downstream controller for the Q1.31 Henon map core. Seeds the core, iterates it,
//   and discards warm-up iterations. Folds each iterate into a tarot card index with

---
 rtl/henon_card_drawer.sv | 154 +++++++++++++++
 tb/tb_henon_card_drawer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/henon_card_drawer.sv
// Henon map sequencer: seeds and iterates the core, folds x into distinct card draws.
// Optional CARD_REVERSAL_EN macro enables the reversed-orientation flag.
module henon_card_drawer #(
   parameter int NUM_CARDS  = 78,
   parameter int DRAW_COUNT = 3,
   parameter int WARMUP     = 8,
   parameter int MAX_ITER   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        draw_req,
   input  logic [31:0] seed_x,
   input  logic [31:0] seed_y,
   input  logic [31:0] perturb,
   output logic        h_start,
   output logic [31:0] h_x_in,
   output logic [31:0] h_y_in,
   output logic [31:0] h_perturb,
   input  logic [31:0] h_x_out,
   input  logic [31:0] h_y_out,
   input  logic        h_done,
   output logic [6:0]  card_idx,
   output logic        card_reversed,
   output logic        card_valid,
   input  logic        card_ready,
   output logic        busy,
   output logic        draw_done,
   output logic        error
);

   localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam int IW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
   localparam int NW = (DRAW_COUNT > 1) ? $clog2(DRAW_COUNT) : 1;

   localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP);
   localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER - 1);
   localparam logic [NW-1:0] CARD_LAST = NW'(DRAW_COUNT - 1);

   typedef enum logic [2:0] {
      IDLE,
      KICK,
      WAIT,
      EVAL,
      EMIT
   } state_t;

   state_t                 state;
   logic [31:0]            cur_x;
   logic [31:0]            cur_y;
   logic [NUM_CARDS-1:0]   used;
   logic [WW-1:0]          warm;
   logic [IW-1:0]          iter;
   logic [NW-1:0]          ncard;
   logic [22:0]            prod;
   logic [6:0]             idx;

   // Offset-binary x scaled onto the deck: -1.0 -> 0, +1.0 -> NUM_CARDS-1
   assign prod = 23'({~cur_x[31], cur_x[30:16]}) * 23'(NUM_CARDS);
   assign idx  = prod[22:16];

   assign h_x_in    = cur_x;
   assign h_y_in    = cur_y;
   assign h_perturb = perturb;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur_x      <= '0;
         cur_y      <= '0;
         used       <= '0;
         warm       <= '0;
         iter       <= '0;
         ncard      <= '0;
         h_start    <= 1'b0;
         card_idx   <= '0;
         card_valid <= 1'b0;
         draw_done  <= 1'b0;
         error      <= 1'b0;
`ifdef CARD_REVERSAL_EN
         card_reversed <= 1'b0;
`endif
      end else begin
         draw_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (draw_req) begin
                  cur_x   <= seed_x;
                  cur_y   <= seed_y;
                  used    <= '0;
                  ncard   <= '0;
                  iter    <= '0;
                  warm    <= WARM_INIT;
                  error   <= 1'b0;
                  h_start <= 1'b1;
                  state   <= KICK;
               end
            end
            KICK: state <= WAIT;
            WAIT: begin
               if (h_done) begin
                  cur_x   <= h_x_out;
                  cur_y   <= h_y_out;
                  h_start <= 1'b0;
                  state   <= EVAL;
               end
            end
            EVAL: begin
               if (warm != '0) begin
                  warm    <= warm - 1'b1;
                  h_start <= 1'b1;
                  state   <= KICK;
               end else if (!used[idx]) begin
                  used[idx]  <= 1'b1;
                  iter       <= '0;
                  card_idx   <= idx;
                  card_valid <= 1'b1;
`ifdef CARD_REVERSAL_EN
                  card_reversed <= cur_y[31] ^ cur_x[0];
`endif
                  state      <= EMIT;
               end else if (iter == ITER_LAST) begin
                  error     <= 1'b1;
                  draw_done <= 1'b1;
                  state     <= IDLE;
               end else begin
                  iter    <= iter + 1'b1;
                  h_start <= 1'b1;
                  state   <= KICK;
               end
            end
            EMIT: begin
               if (card_ready) begin
                  card_valid <= 1'b0;
                  if (ncard == CARD_LAST) begin
                     draw_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     ncard   <= ncard + 1'b1;
                     h_start <= 1'b1;
                     state   <= KICK;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef CARD_REVERSAL_EN
   assign card_reversed = 1'b0;
`endif

endmodule

// File: tb/tb_henon_card_drawer.sv
// Directed bench for henon_card_drawer with a stub Henon core per instance.
// Instance A: WARMUP=0, MAX_ITER=4; instance B: WARMUP=8, DRAW_COUNT=1.
module tb_henon_card_drawer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        draw_req_a = 1'b0;
   logic        draw_req_b = 1'b0;
   logic [31:0] seed_x = 32'h0;
   logic [31:0] seed_y = 32'h0;
   logic [31:0] perturb = 32'h0;
   logic        ready_a = 1'b1;
   logic        ready_b = 1'b1;

   logic        hs_a, hd_a, cv_a, cr_a, busy_a, dd_a, err_a;
   logic [31:0] hxi_a, hyi_a, hp_a, hxo_a, hyo_a;
   logic [6:0]  ci_a;
   logic        hs_b, hd_b, cv_b, cr_b, busy_b, dd_b, err_b;
   logic [31:0] hxi_b, hyi_b, hp_b, hxo_b, hyo_b;
   logic [6:0]  ci_b;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef CARD_REVERSAL_EN
   localparam logic REV_EXP = 1'b1;
`else
   localparam logic REV_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   henon_card_drawer #(
      .NUM_CARDS(78), .DRAW_COUNT(3), .WARMUP(0), .MAX_ITER(4)
   ) dut_a (
      .clk(clk), .rst(rst), .draw_req(draw_req_a),
      .seed_x(seed_x), .seed_y(seed_y), .perturb(perturb),
      .h_start(hs_a), .h_x_in(hxi_a), .h_y_in(hyi_a),
      .h_perturb(hp_a), .h_x_out(hxo_a), .h_y_out(hyo_a),
      .h_done(hd_a), .card_idx(ci_a), .card_reversed(cr_a),
      .card_valid(cv_a), .card_ready(ready_a), .busy(busy_a),
      .draw_done(dd_a), .error(err_a)
   );

   henon_card_drawer #(
      .NUM_CARDS(78), .DRAW_COUNT(1), .WARMUP(8), .MAX_ITER(64)
   ) dut_b (
      .clk(clk), .rst(rst), .draw_req(draw_req_b),
      .seed_x(seed_x), .seed_y(seed_y), .perturb(perturb),
      .h_start(hs_b), .h_x_in(hxi_b), .h_y_in(hyi_b),
      .h_perturb(hp_b), .h_x_out(hxo_b), .h_y_out(hyo_b),
      .h_done(hd_b), .card_idx(ci_b), .card_reversed(cr_b),
      .card_valid(cv_b), .card_ready(ready_b), .busy(busy_b),
      .draw_done(dd_b), .error(err_b)
   );

   // Stub core A: programmable x table, done 3 cycles after start rise
   logic [31:0] xa_tab [16];
   logic [31:0] ya = 32'h0;
   logic [3:0]  ka;
   logic [1:0]  cnt_a;
   logic        pa;
   int          dd_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pa <= 0; cnt_a <= 0; hd_a <= 0; ka <= 0;
         hxo_a <= 0; hyo_a <= 0; dd_cnt <= 0;
      end else begin
         pa   <= hs_a;
         hd_a <= 0;
         if (dd_a) dd_cnt <= dd_cnt + 1;
         if (hs_a && !pa) cnt_a <= 2'd3;
         else if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1) begin
               hd_a  <= 1;
               hxo_a <= xa_tab[ka];
               hyo_a <= ya;
               ka    <= ka + 1;
            end
         end
      end
   end

   // Stub core B: always x=0, counts start rises and done pulses
   logic [1:0] cnt_b;
   logic       pb;
   int         rises_b, dones_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pb <= 0; cnt_b <= 0; hd_b <= 0;
         hxo_b <= 0; hyo_b <= 0; rises_b <= 0; dones_b <= 0;
      end else begin
         pb   <= hs_b;
         hd_b <= 0;
         if (hs_b && !pb) begin
            cnt_b   <= 2'd3;
            rises_b <= rises_b + 1;
         end else if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) begin
               hd_b    <= 1;
               hxo_b   <= 32'h0;
               dones_b <= dones_b + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
   endtask

   task automatic draw_a();
      @(negedge clk); draw_req_a = 1;
      @(negedge clk); draw_req_a = 0;
   endtask

   task automatic wait_a(input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cv_a) break;
      end
      chk(tag, cv_a, 1);
   endtask

   task automatic idle_a(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (!busy_a) break;
         @(negedge clk);
      end
      chk(tag, busy_a, 0);
   endtask

   initial begin
      logic bad;
      for (int i = 0; i < 16; i++) xa_tab[i] = 32'h0;

      // Reset state
      @(negedge clk); rst = 1;
      #1;
      chk("rst_h_start", hs_a, 0);
      chk("rst_card_valid", cv_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", dd_a, 0);
      chk("rst_error", err_a, 0);
      chk("rst_idx", ci_a, 0);
      chk("rst_hx", hxi_a, 0);
      @(negedge clk); rst = 0;

      // Mapping: three distinct x values -> 0, 39, 77
      xa_tab[0] = 32'h8000_0000;
      xa_tab[1] = 32'h0000_0000;
      xa_tab[2] = 32'h7FFF_FFFF;
      ready_a = 1;
      draw_a();
      wait_a("map_v0"); chk("map_c0", ci_a, 0);
      wait_a("map_v1"); chk("map_c1", ci_a, 39);
      wait_a("map_v2"); chk("map_c2", ci_a, 77);
      idle_a("map_idle");
      @(negedge clk);
      chk("map_done_cnt", dd_cnt, 1);
      chk("map_done_low", dd_a, 0);
      chk("map_error", err_a, 0);

      // Duplicate rejection and timeout
      do_reset();
      for (int i = 0; i < 16; i++) xa_tab[i] = 32'h0;
      draw_a();
      wait_a("dup_v0"); chk("dup_c0", ci_a, 39);
      idle_a("dup_idle");
      chk("dup_error", err_a, 1);
      chk("dup_valid", cv_a, 0);
      @(negedge clk);
      chk("dup_done_cnt", dd_cnt, 1);
      repeat (3) @(negedge clk);
      chk("dup_sticky", err_a, 1);
      draw_a();
      chk("dup_err_clr", err_a, 0);
      idle_a("dup_idle2");

      // Backpressure plus reversal flag
      do_reset();
      ya = 32'h8000_0000;
      ready_a = 0;
      draw_a();
      wait_a("bp_v0");
      chk("bp_c0", ci_a, 39);
      chk("bp_rev", cr_a, REV_EXP);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!cv_a || ci_a != 7'd39 || hs_a) bad = 1;
      end
      chk("bp_hold", bad, 0);
      ready_a = 1;
      @(negedge clk);
      chk("bp_accept", cv_a, 0);
      chk("bp_restart", hs_a, 1);
      idle_a("bp_idle");
      ya = 32'h0;

      // Reset mid-draw, then clean restart from seeds
      do_reset();
      xa_tab[0] = 32'h8000_0000;
      xa_tab[1] = 32'h0000_0000;
      xa_tab[2] = 32'h7FFF_FFFF;
      seed_x = 32'h1234_5678;
      draw_a();
      chk("rs_seed", hxi_a, 32'h1234_5678);
      repeat (2) @(negedge clk);
      chk("rs_wait_start", hs_a, 1);
      rst = 1;
      #1;
      chk("rs_h_start", hs_a, 0);
      chk("rs_busy", busy_a, 0);
      chk("rs_valid", cv_a, 0);
      chk("rs_hx", hxi_a, 0);
      @(negedge clk); rst = 0;
      draw_a();
      chk("rs_seed2", hxi_a, 32'h1234_5678);
      wait_a("rs_v0"); chk("rs_c0", ci_a, 0);
      wait_a("rs_v1"); chk("rs_c1", ci_a, 39);
      wait_a("rs_v2"); chk("rs_c2", ci_a, 77);
      idle_a("rs_idle");

      // Warm-up: 8 discarded iterations, then 1 candidate
      do_reset();
      @(negedge clk); draw_req_b = 1;
      @(negedge clk); draw_req_b = 0;
      for (int i = 0; i < 300; i++) begin
         if (cv_b) break;
         @(negedge clk);
      end
      chk("wu_valid", cv_b, 1);
      chk("wu_idx", ci_b, 39);
      chk("wu_rises", rises_b, 9);
      chk("wu_dones", dones_b, 9);
      repeat (2) @(negedge clk);
      chk("wu_idle", busy_b, 0);
      chk("wu_error", err_b, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
